// File: rtl/mac_tx_arbiter_pkg.sv
// Shared definitions for the MAC transmit arbiter: FSM encoding, gap sizing
// and parameter legality helpers.
package mac_tx_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_SEND = 4'b0010,
    ST_DROP = 4'b0100,
    ST_GAP  = 4'b1000
  } state_e;

  // Idle cycles needed to cover the inter-frame gap, rounded up to whole beats.
  function automatic int gap_cyc(input int ifg_bytes, input int keep_w);
    return (ifg_bytes + keep_w - 1) / keep_w;
  endfunction

  function automatic bit data_w_legal(input int data_w);
    return (data_w == 16) || (data_w == 32) || (data_w == 64);
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// Requester-side and MAC-side bundle of the transmit arbiter; the slave
// modport is the arbiter, the master modport is the surrounding fabric.
interface mac_tx_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 16,
  parameter int KEEP_W = DATA_W / 8
) ();

  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ*KEEP_W-1:0] req_keep_i;
  logic [N_REQ-1:0]        req_last_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic                    mac_valid_o;
  logic [DATA_W-1:0]       mac_data_o;
  logic [KEEP_W-1:0]       mac_keep_o;
  logic                    mac_last_o;
  logic                    mac_err_o;
  logic                    mac_ready_i;
  logic [N_REQ-1:0]        grant_o;

  modport master (
    output req_valid_i, req_data_i, req_keep_i, req_last_i, mac_ready_i,
    input  req_ready_o, mac_valid_o, mac_data_o, mac_keep_o, mac_last_o,
           mac_err_o, grant_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_keep_i, req_last_i, mac_ready_i,
    output req_ready_o, mac_valid_o, mac_data_o, mac_keep_o, mac_last_o,
           mac_err_o, grant_o
  );

endinterface

// File: rtl/mac_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo N_REQ, returned one-hot.
module mac_rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt
);

  // Scan from the pointer; the found flag keeps only the first hit.
  always_comb begin
    logic w_found;
    int   w_idx;
    o_gnt   = {N_REQ{1'b0}};
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = (int'(i_ptr) + i) % N_REQ;
      if (i_req[w_idx] && !w_found) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing the MAC TX datapath between N_REQ
// sources, with zero-latency pass-through, inter-frame gap and truncation.
module mac_tx_arbiter
  import mac_tx_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = 16,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int IFG_BYTES = 12,
  parameter int MAX_BEATS = 1536 / (DATA_W / 8)
) (
  input logic             clk,
  input logic             nreset,
  mac_tx_arbiter_if.slave bus
);

  localparam int PTR_W   = $clog2(N_REQ);
  localparam int CNT_W   = $clog2(MAX_BEATS + 1);
  localparam int GAP_CYC = gap_cyc(IFG_BYTES, KEEP_W);
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0] SAT_CNT  = CNT_W'(MAX_BEATS);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

  if (!data_w_legal(DATA_W)) begin : g_bad_data_w
    $error("mac_tx_arbiter: DATA_W must be 16, 32 or 64");
  end

  state_e             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_ptr_nxt, w_adv_ptr;
  logic [N_REQ-1:0]   r_grant, w_grant_nxt, w_pick;
  logic [CNT_W-1:0]   r_beat_cnt, w_beat_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
  logic               w_own_valid, w_own_last;
  logic [DATA_W-1:0]  w_own_data;
  logic [KEEP_W-1:0]  w_own_keep;
  logic [2:0]         w_own_idx;

  mac_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .i_req (bus.req_valid_i),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick)
  );

  // Owner mux: AND-OR select keyed by the one-hot grant.
  always_comb begin
    w_own_valid = |(bus.req_valid_i & r_grant);
    w_own_last  = |(bus.req_last_i & r_grant);
    w_own_data  = {DATA_W{1'b0}};
    w_own_keep  = {KEEP_W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      w_own_data = w_own_data | (bus.req_data_i[k*DATA_W +: DATA_W] & {DATA_W{r_grant[k]}});
      w_own_keep = w_own_keep | (bus.req_keep_i[k*KEEP_W +: KEEP_W] & {KEEP_W{r_grant[k]}});
    end
  end

  assign w_own_idx = onehot_to_idx(8'(r_grant));

  // Pointer to the requester just after the current owner.
  always_comb begin
    if (int'(w_own_idx) >= N_REQ - 1) begin
      w_adv_ptr = PTR_W'(0);
    end else begin
      w_adv_ptr = PTR_W'(int'(w_own_idx) + 1);
    end
  end

  // State, pointer, grant and counter registers.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= PTR_W'(0);
      r_grant    <= {N_REQ{1'b0}};
      r_beat_cnt <= CNT_W'(0);
      r_gap_cnt  <= GAP_W'(0);
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_ptr_nxt;
      r_grant    <= w_grant_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_gap_cnt  <= w_gap_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    logic w_hs;
    logic w_trunc;
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_rr_ptr;
    w_grant_nxt     = r_grant;
    w_beat_nxt      = r_beat_cnt;
    w_gap_nxt       = r_gap_cnt;
    w_hs            = 1'b0;
    w_trunc         = 1'b0;
    bus.req_ready_o = {N_REQ{1'b0}};
    bus.mac_valid_o = 1'b0;
    bus.mac_data_o  = w_own_data;
    bus.mac_keep_o  = w_own_keep;
    bus.mac_last_o  = 1'b0;
    bus.mac_err_o   = 1'b0;
    bus.grant_o     = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req_valid_i) begin
          w_grant_nxt = w_pick;
          w_beat_nxt  = CNT_W'(0);
          w_state_nxt = ST_SEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        w_hs            = w_own_valid & bus.mac_ready_i;
        w_trunc         = w_hs & ~w_own_last & (r_beat_cnt == LAST_CNT);
        bus.mac_valid_o = w_own_valid;
        bus.mac_last_o  = w_own_last | w_trunc;
        bus.mac_err_o   = w_trunc;
        bus.req_ready_o = r_grant & {N_REQ{bus.mac_ready_i}};
        if (w_hs && (r_beat_cnt != SAT_CNT)) begin
          w_beat_nxt = r_beat_cnt + CNT_W'(1);
        end else begin
          w_beat_nxt = r_beat_cnt;
        end
        if (w_hs && w_own_last) begin
          w_state_nxt = ST_GAP;
          w_ptr_nxt   = w_adv_ptr;
          w_grant_nxt = {N_REQ{1'b0}};
          w_gap_nxt   = GAP_LOAD;
        end else if (w_trunc) begin
          w_state_nxt = ST_DROP;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_DROP: begin
        // Sink the rest of a truncated frame without forwarding it.
        bus.req_ready_o = r_grant;
        if (w_own_valid && w_own_last) begin
          w_state_nxt = ST_GAP;
          w_ptr_nxt   = w_adv_ptr;
          w_grant_nxt = {N_REQ{1'b0}};
          w_gap_nxt   = GAP_LOAD;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_W'(0)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap_cnt - GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = {N_REQ{1'b0}};
      end
    endcase
  end

endmodule
